// File: rtl/param_dump_reader.sv
// Streams a window of parameter memory into the write side of an async FIFO for host readback.
// Optional trailing checksum word when PARAM_DUMP_CHECKSUM_EN is defined.
module param_dump_reader #(
    parameter int DSIZE  = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DSIZE-1:0]  mem_rdata,
    output logic              fifo_winc,
    output logic [DSIZE-1:0]  fifo_wdata,
    input  logic              fifo_wfull
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [AWIDTH:0]   CNT_ZERO = {(AWIDTH+1){1'b0}};
    localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    state_t            state_r, state_nxt_s;
    logic [AWIDTH-1:0] addr_r;
    logic [AWIDTH:0]   rd_left_r, wr_left_r;
    logic [DSIZE-1:0]  buf0_r, buf1_r;
    logic [1:0]        cnt_r;
    logic              inflight_r, done_r;
    logic              pop_s, rd_s, winc_s, fin_s;
    logic [2:0]        occ_s;
    logic [DSIZE-1:0]  wdata_s;
    logic              accept_s;

`ifdef PARAM_DUMP_CHECKSUM_EN
    logic [DSIZE-1:0]  sum_r;

    function automatic logic [DSIZE-1:0] csum_add(input logic [DSIZE-1:0] acc,
                                                  input logic [DSIZE-1:0] word);
        return acc + word;
    endfunction
`endif

    assign accept_s   = (state_r == ST_IDLE) && start;
    assign busy       = (state_r == ST_RUN);
    assign done       = done_r;
    assign mem_rd_en  = rd_s;
    assign mem_addr   = addr_r;
    assign fifo_winc  = winc_s;
    assign fifo_wdata = wdata_s;

    // Next-state, read credit and FIFO write decode
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        rd_s        = 1'b0;
        winc_s      = 1'b0;
        fin_s       = 1'b0;
        occ_s       = 3'd0;
        wdata_s     = buf0_r;
        case (state_r)
            ST_IDLE: begin
`ifdef PARAM_DUMP_CHECKSUM_EN
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
`else
                if (start && (length == CNT_ZERO)) begin
                    state_nxt_s = ST_IDLE;
                    fin_s       = 1'b1;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
`endif
            end
            ST_RUN: begin
                pop_s = (cnt_r != 2'd0) && !fifo_wfull;
                // Occupancy once this cycle's pop and last cycle's read land; keeps buffer <= 2
                occ_s = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
                rd_s  = (rd_left_r != CNT_ZERO) && (occ_s < 3'd2);
`ifdef PARAM_DUMP_CHECKSUM_EN
                if (wr_left_r == CNT_ZERO) begin
                    wdata_s = sum_r;
                    winc_s  = !fifo_wfull;
                    fin_s   = !fifo_wfull;
                end else begin
                    winc_s  = pop_s;
                    fin_s   = 1'b0;
                end
`else
                winc_s = pop_s;
                fin_s  = pop_s && (wr_left_r == CNT_ONE);
`endif
                if (fin_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, completion pulse and read-in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            done_r     <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            done_r     <= fin_s;
            inflight_r <= rd_s;
        end
    end

    // Address and word counters, plus running checksum when built in
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r    <= {AWIDTH{1'b0}};
            rd_left_r <= CNT_ZERO;
            wr_left_r <= CNT_ZERO;
`ifdef PARAM_DUMP_CHECKSUM_EN
            sum_r     <= {DSIZE{1'b0}};
`endif
        end else if (accept_s) begin
            addr_r    <= base_addr;
            rd_left_r <= length;
            wr_left_r <= length;
`ifdef PARAM_DUMP_CHECKSUM_EN
            sum_r     <= {DSIZE{1'b0}};
`endif
        end else begin
            if (rd_s) begin
                addr_r    <= addr_r + ADDR_ONE;
                rd_left_r <= rd_left_r - CNT_ONE;
            end
            if (pop_s) begin
                wr_left_r <= wr_left_r - CNT_ONE;
`ifdef PARAM_DUMP_CHECKSUM_EN
                sum_r     <= csum_add(sum_r, buf0_r);
`endif
            end
        end
    end

    // Two-entry output buffer: buf0_r is the head, push lands behind any surviving entry
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_r <= {DSIZE{1'b0}};
            buf1_r <= {DSIZE{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        buf0_r <= mem_rdata;
                    end else begin
                        buf1_r <= mem_rdata;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    buf0_r <= buf1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        buf0_r <= buf1_r;
                        buf1_r <= mem_rdata;
                    end else begin
                        buf0_r <= mem_rdata;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule
